// File: rtl/vga_pkg.sv
// Shared constants for the menu text overlay: writer command encodings and
// text grid geometry.
package vga_pkg;

  localparam logic [1:0] TXT_CMD_CHAR    = 2'd0;
  localparam logic [1:0] TXT_CMD_NEWLINE = 2'd1;
  localparam logic [1:0] TXT_CMD_HOME    = 2'd2;
  localparam logic [1:0] TXT_CMD_CLEAR   = 2'd3;

  localparam int TXT_COLS = 16;
  localparam int TXT_ROWS = 16;

endpackage

// File: rtl/text_ram.sv
// Simple dual-port character store: one synchronous write port and one
// registered read-first read port, shaped for BRAM/LUTRAM inference.
module text_ram
  import vga_pkg::*;
#(
  parameter int          DATA_W  = 7,
  parameter int          ADDR_W  = 8,
  parameter logic [6:0]  RST_VAL = 7'h00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = TXT_COLS * TXT_ROWS;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read samples the array before this edge's write lands, so a same-cycle
  // write to the read address shows up one cycle later.
  always_ff @(posedge clk) begin
    if (rst) rdata <= RST_VAL[DATA_W-1:0];
    else     rdata <= mem[raddr];
  end

endmodule

// File: rtl/menu_text_buffer.sv
// Writable 16x16 menu text buffer: cursor-driven command stream on the write
// side, ROM-compatible char_xy -> char_code lookup on the read side.
module menu_text_buffer
  import vga_pkg::*;
#(
  parameter logic [6:0] BLANK_CODE   = 7'h00,
  parameter bit         CLEAR_ON_RST = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [1:0] wr_cmd,
  input  logic [6:0] wr_char,
  output logic [7:0] cursor_xy,
  output logic       busy,
  input  logic [7:0] char_xy,
  output logic [6:0] char_code
);

  localparam logic STATE_IDLE  = 1'b0;
  localparam logic STATE_SWEEP = 1'b1;

  logic       state;
  logic [7:0] sweep_cnt;
  logic [7:0] cursor;
  logic       accept;
  logic       ram_we;
  logic [7:0] ram_waddr;
  logic [6:0] ram_wdata;

  assign wr_ready  = (state == STATE_IDLE);
  assign busy      = (state == STATE_SWEEP);
  assign accept    = wr_valid && wr_ready;
  assign cursor_xy = cursor;

  // The write port is shared between the clear sweep and CHAR commands; the
  // two never overlap because commands are only accepted in IDLE.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = cursor;
    ram_wdata = wr_char;
    if (!rst) begin
      if (state == STATE_SWEEP) begin
        ram_we    = 1'b1;
        ram_waddr = sweep_cnt;
        ram_wdata = BLANK_CODE;
      end else if (accept && wr_cmd == TXT_CMD_CHAR) begin
        ram_we = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= CLEAR_ON_RST ? STATE_SWEEP : STATE_IDLE;
      sweep_cnt <= 8'h00;
      cursor    <= 8'h00;
    end else begin
      case (state)
        STATE_SWEEP: begin
          sweep_cnt <= sweep_cnt + 8'h01;
          if (sweep_cnt == 8'hFF) begin
            state  <= STATE_IDLE;
            cursor <= 8'h00;
          end
        end
        default: begin
          if (accept) begin
            case (wr_cmd)
              TXT_CMD_CHAR:    cursor <= cursor + 8'h01;
              TXT_CMD_NEWLINE: cursor <= {cursor[7:4] + 4'h1, 4'h0};
              TXT_CMD_HOME:    cursor <= 8'h00;
              default: begin
                state     <= STATE_SWEEP;
                sweep_cnt <= 8'h00;
                cursor    <= 8'h00;
              end
            endcase
          end
        end
      endcase
    end
  end

  text_ram #(
    .DATA_W  (7),
    .ADDR_W  (8),
    .RST_VAL (BLANK_CODE)
  ) u_text_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (char_xy),
    .rdata (char_code)
  );

endmodule
